// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: port ids, request bundle, strobe width.
package mem_arb_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    localparam int PKG_STRB_W = strb_w(PKG_DATA_W);

    typedef enum logic {
        PORT_IFU = 1'b0,
        PORT_LSU = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                  wr;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
        logic [PKG_STRB_W-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/mem_arb_resp_buf.sv
// Per-port response register: holds valid+rdata until consumed, reloads on a new grant.
module mem_arb_resp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              grant,
    input  logic              grant_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        if (valid_q && resp_ready) begin
            valid_d = 1'b0;
        end
        // A grant in the consuming cycle wins, so the slot reloads instead of clearing.
        if (grant) begin
            valid_d = 1'b1;
            rdata_d = grant_wr ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Merges IFU (port 1) and LSU (port 2) requests onto one memory port, one grant per cycle.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int DATA_W = PKG_DATA_W,
    localparam int STRB_W = strb_w(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_wr,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [STRB_W-1:0] p1_req_wstrb,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [DATA_W-1:0] p1_resp_rdata,

    input  logic              p2_req_valid,
    output logic              p2_req_ready,
    input  logic              p2_req_wr,
    input  logic [ADDR_W-1:0] p2_req_addr,
    input  logic [DATA_W-1:0] p2_req_wdata,
    input  logic [STRB_W-1:0] p2_req_wstrb,
    output logic              p2_resp_valid,
    input  logic              p2_resp_ready,
    output logic [DATA_W-1:0] p2_resp_rdata,

    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic p1_elig, p2_elig;
    logic grant_p1, grant_p2;
    req_t p1_req, p2_req, sel_req;

    // Eligibility looks only at a port's own response slot, never the other port's.
    assign p1_elig = !reset && p1_req_valid && (!p1_resp_valid || p1_resp_ready);
    assign p2_elig = !reset && p2_req_valid && (!p2_resp_valid || p2_resp_ready);

`ifdef MEM_ARB_RR_EN
    port_id_t last_grant_q, last_grant_d;

    always_comb begin
        grant_p1     = 1'b0;
        grant_p2     = 1'b0;
        last_grant_d = last_grant_q;
        if (p1_elig && p2_elig) begin
            if (last_grant_q == PORT_LSU) grant_p1 = 1'b1;
            else                          grant_p2 = 1'b1;
        end else begin
            grant_p1 = p1_elig;
            grant_p2 = p2_elig;
        end
        if (grant_p1)      last_grant_d = PORT_IFU;
        else if (grant_p2) last_grant_d = PORT_LSU;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_grant_q <= PORT_LSU;
        else       last_grant_q <= last_grant_d;
    end
`else
    always_comb begin
        grant_p2 = p2_elig;
        grant_p1 = p1_elig && !p2_elig;
    end
`endif

    assign p1_req_ready = grant_p1;
    assign p2_req_ready = grant_p2;

    assign p1_req = '{wr: p1_req_wr, addr: p1_req_addr, wdata: p1_req_wdata, wstrb: p1_req_wstrb};
    assign p2_req = '{wr: p2_req_wr, addr: p2_req_addr, wdata: p2_req_wdata, wstrb: p2_req_wstrb};

    always_comb begin
        sel_req   = grant_p1 ? p1_req : p2_req;
        mem_en    = grant_p1 || grant_p2;
        mem_wr    = mem_en && sel_req.wr;
        mem_addr  = sel_req.addr;
        mem_wdata = sel_req.wdata;
        mem_wstrb = sel_req.wstrb;
    end

    mem_arb_resp_buf #(.DATA_W(DATA_W)) u_resp_p1 (
        .clock      (clock),
        .reset      (reset),
        .grant      (grant_p1),
        .grant_wr   (p1_req_wr),
        .mem_rdata  (mem_rdata),
        .resp_ready (p1_resp_ready),
        .resp_valid (p1_resp_valid),
        .resp_rdata (p1_resp_rdata)
    );

    mem_arb_resp_buf #(.DATA_W(DATA_W)) u_resp_p2 (
        .clock      (clock),
        .reset      (reset),
        .grant      (grant_p2),
        .grant_wr   (p2_req_wr),
        .mem_rdata  (mem_rdata),
        .resp_ready (p2_resp_ready),
        .resp_valid (p2_resp_valid),
        .resp_rdata (p2_resp_rdata)
    );

endmodule
